apu_voice_mixer: RTL and testbench

Parametrised multi-voice audio unit for the VGA-timed game designs. It drives NUM_VOICES independent percussion/tone voices, each with its own trigger, linear decay envelope and either a noise or a square-wave generator. The voices are summed and rendered as a 1-bit PWM `sound` output, using `pix_x` as the PWM ramp. It supersedes the single-snare unit and sits beside the video timing generator, taking `pix_x`, `pix_y` and `frame_end` from it.

---
 rtl/apu_voice_mixer.sv | 155 +++++++++++++++
 tb/tb_apu_voice_mixer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_voice_mixer.sv
// rtl/apu_voice_mixer.sv - multi-voice trigger/decay audio unit mixed to a 1-bit PWM output
// Define APU_FRAME_LATCH_EN to latch tone_period into shadow registers on frame_end.
module apu_voice_mixer #(
  parameter int         NUM_VOICES     = 4,
  parameter logic [7:0] NOISE_MASK     = 8'b0000_0010,
  parameter int         ENV_STEP_LINES = 188,
  parameter int         NOISE_DIV      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_VOICES-1:0]   trigger,
  input  logic [8*NUM_VOICES-1:0] tone_period,
  input  logic                    frame_end,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  output logic                    sound,
  output logic [NUM_VOICES-1:0]   voice_active
);
  localparam int STEP_W = $clog2(ENV_STEP_LINES + 1);
  localparam int DIV_W  = $clog2(NOISE_DIV + 1);
  localparam int MIX_W  = 5 + $clog2(NUM_VOICES);

  typedef enum logic {IDLE = 1'b0, DECAY = 1'b1} state_t;

  state_t                state_q [NUM_VOICES];
  state_t                state_d [NUM_VOICES];
  logic [4:0]            env_q   [NUM_VOICES];
  logic [4:0]            env_d   [NUM_VOICES];
  logic [STEP_W-1:0]     step_q  [NUM_VOICES];
  logic [STEP_W-1:0]     step_d  [NUM_VOICES];
  logic [7:0]            tone_q  [NUM_VOICES];
  logic [7:0]            tone_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] square_q, square_d;
  logic [NUM_VOICES-1:0] noise_q, noise_d;
  logic [NUM_VOICES-1:0] trig_prev_q, trig_prev_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  sound_q, sound_d;

  logic [8*NUM_VOICES-1:0] period_all;
  logic                    line_tick, noise_tick, edge_det, gen_bit;
  logic [7:0]              period_eff;
  logic [4:0]              level;
  logic [MIX_W-1:0]        mix;
  logic [15:0]             mix_wide;
  logic [7:0]              mix_sat;

`ifdef APU_FRAME_LATCH_EN
  logic [8*NUM_VOICES-1:0] shadow_q, shadow_d;
  logic                    unused_inputs;

  always_comb shadow_d = frame_end ? tone_period : shadow_q;

  always_ff @(posedge clk) begin
    if (reset) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end

  assign period_all    = shadow_q;
  assign unused_inputs = ^pix_y;
`else
  logic unused_inputs;

  assign period_all    = tone_period;
  assign unused_inputs = ^{pix_y, frame_end};
`endif

  always_comb begin
    line_tick   = (pix_x == 10'd0);
    noise_tick  = line_tick && (div_q == DIV_W'(NOISE_DIV - 1));
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    div_d       = div_q;
    if (line_tick) div_d = noise_tick ? '0 : div_q + DIV_W'(1);
    trig_prev_d = trigger;
    square_d    = square_q;
    noise_d     = noise_q;
    edge_det    = 1'b0;
    gen_bit     = 1'b0;
    period_eff  = 8'd0;
    level       = 5'd0;
    mix         = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      state_d[i] = state_q[i];
      env_d[i]   = env_q[i];
      step_d[i]  = step_q[i];
      tone_d[i]  = tone_q[i];
      edge_det   = trigger[i] & ~trig_prev_q[i];
      period_eff = period_all[8*i +: 8];
      if (NOISE_MASK[i] && noise_tick) noise_d[i] = noise_q[i] ^ lfsr_q[i];
      // A trigger edge wins over any same-cycle envelope step or return to idle.
      if (edge_det) begin
        state_d[i]  = DECAY;
        env_d[i]    = 5'd31;
        step_d[i]   = '0;
        tone_d[i]   = 8'd0;
        square_d[i] = 1'b1;
      end else if (state_q[i] == DECAY && line_tick) begin
        if (step_q[i] == STEP_W'(ENV_STEP_LINES - 1)) begin
          step_d[i] = '0;
          env_d[i]  = env_q[i] - 5'd1;
          if (env_q[i] == 5'd1) state_d[i] = IDLE;
        end else begin
          step_d[i] = step_q[i] + STEP_W'(1);
        end
        if ({1'b0, tone_q[i]} + 9'd1 >= {1'b0, period_eff}) begin
          square_d[i] = ~square_q[i];
          tone_d[i]   = 8'd0;
        end else begin
          tone_d[i] = tone_q[i] + 8'd1;
        end
      end
      if (period_eff == 8'd0) square_d[i] = 1'b0;
      gen_bit = NOISE_MASK[i] ? noise_q[i] : square_q[i];
      level   = (state_q[i] == DECAY && gen_bit) ? env_q[i] : 5'd0;
      mix     = mix + MIX_W'(level);
      voice_active[i] = (state_q[i] == DECAY);
    end
    mix_wide = 16'(mix);
    mix_sat  = (mix_wide > 16'd255) ? 8'hFF : mix_wide[7:0];
    sound_d  = ({mix_sat, 2'b00} > pix_x);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= IDLE;
        env_q[i]   <= 5'd0;
        step_q[i]  <= '0;
        tone_q[i]  <= 8'd0;
      end
      square_q    <= '0;
      noise_q     <= '0;
      trig_prev_q <= '0;
      lfsr_q      <= 16'hACE1;
      div_q       <= '0;
      sound_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= state_d[i];
        env_q[i]   <= env_d[i];
        step_q[i]  <= step_d[i];
        tone_q[i]  <= tone_d[i];
      end
      square_q    <= square_d;
      noise_q     <= noise_d;
      trig_prev_q <= trig_prev_d;
      lfsr_q      <= lfsr_d;
      div_q       <= div_d;
      sound_q     <= sound_d;
    end
  end

  assign sound = sound_q;

endmodule

// File: tb/tb_apu_voice_mixer.sv
// tb/tb_apu_voice_mixer.sv - directed vector bench for apu_voice_mixer
module tb_apu_voice_mixer;
  localparam int NV   = 4;
  localparam int ESL  = 5;
  localparam int NDIV = 3;

  logic          clk;
  logic          reset;
  logic [NV-1:0] trigger;
  logic [31:0]   tone_period;
  logic          frame_end;
  logic [9:0]    pix_x, pix_y;
  logic          sound;
  logic [NV-1:0] voice_active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]      trig;
    logic [31:0]     period;
    logic [3:0][2:0] units;
  } vec_t;

  vec_t vecs [9];
  // Sound-high count over one line window, indexed by number of voices at env 31.
  int cnt_tab [5] = '{0, 7, 15, 23, 31};

  apu_voice_mixer #(
    .NUM_VOICES(NV), .NOISE_MASK(8'h02), .ENV_STEP_LINES(ESL), .NOISE_DIV(NDIV)
  ) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .tone_period(tone_period),
    .frame_end(frame_end), .pix_x(pix_x), .pix_y(pix_y),
    .sound(sound), .voice_active(voice_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [9:0] xval(input int k);
    if (k <= 30)      return 10'(k * 16);
    else if (k == 31) return 10'd495;
    else              return 10'((k - 1) * 16);
  endfunction

  // 64 cycles per line, 8 lines per frame; columns include 495 and 496.
  int px_k = 0;
  int px_line = 0;
  initial begin
    pix_x = 10'd0; pix_y = 10'd0; frame_end = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      px_k = (px_k + 1) % 64;
      if (px_k == 0) px_line = (px_line + 1) % 8;
      pix_x     = xval(px_k);
      pix_y     = 10'(px_line);
      frame_end = (px_k == 63 && px_line == 7);
    end
  end

  // Reference noise sample for voice 1.
  logic [15:0] m_lfsr;
  int          m_div;
  logic        m_ns;
  always @(posedge clk) begin
    if (reset) begin
      m_lfsr = 16'hACE1; m_div = 0; m_ns = 1'b0;
    end else begin
      if (pix_x == 10'd0) begin
        if (m_div == NDIV - 1) begin
          m_div = 0;
          m_ns  = m_ns ^ m_lfsr[1];
        end else m_div = m_div + 1;
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic sync_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pix_x != 10'd0 && n < 200);
    if (pix_x != 10'd0) check("sync_tick_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) sync_tick();
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_end !== 1'b1 && n < 2000);
    if (frame_end !== 1'b1) check("wait_frame_timeout", 32'(n), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; trigger = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Starts at the negedge of a line_tick cycle and ends at the next one.
  task automatic measure_line(output int hi, output logic ns);
    @(negedge clk);
    ns = m_ns;
    hi = 0;
    repeat (63) begin
      @(negedge clk);
      hi += int'(sound);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] trig, input logic [31:0] per,
                              input int u1, input int u2, input int u3, input int u4);
    vec_t r;
    r.trig = trig; r.period = per;
    r.units = {3'(u4), 3'(u3), 3'(u2), 3'(u1)};
    return r;
  endfunction

  initial begin
    int   hi, act;
    logic ns;
    reset = 1'b1; trigger = '0; tone_period = '0;
    vecs[0] = mk(4'b0001, 32'h0000_0002, 1, 0, 0, 1);
    vecs[1] = mk(4'b0001, 32'h0000_0001, 0, 1, 0, 1);
    vecs[2] = mk(4'b1101, 32'h0101_0101, 0, 3, 0, 3);
    vecs[3] = mk(4'b0100, 32'h0003_0000, 1, 1, 0, 0);
    vecs[4] = mk(4'b1000, 32'h0000_0000, 0, 0, 0, 0);
    vecs[5] = mk(4'b1111, 32'h0101_0101, 0, 3, 0, 3);
    vecs[6] = mk(4'b0010, 32'h0000_0000, 0, 0, 0, 0);
    vecs[7] = mk(4'b0101, 32'h0003_0002, 2, 1, 0, 1);
    vecs[8] = mk(4'b0001, 32'h0000_00FF, 1, 1, 1, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    hi = 0; act = 0;
    repeat (2 * 8 * 64) begin
      @(negedge clk);
      hi  += int'(sound);
      act += int'(voice_active != '0);
    end
    check("idle_sound", 32'(hi), 32'd0);
    check("idle_active", 32'(act), 32'd0);

    for (int v = 0; v < 9; v++) begin
      pulse_reset();
      tone_period = vecs[v].period;
      wait_frame();
      sync_tick();
      repeat (5) @(negedge clk);
      check($sformatf("vec%0d_pre_active", v), 32'(voice_active), 32'd0);
      trigger = vecs[v].trig;
      @(negedge clk);
      check($sformatf("vec%0d_start", v), 32'(voice_active), 32'(vecs[v].trig));
      trigger = '0;
      sync_tick();
      for (int j = 0; j < 4; j++) begin
        measure_line(hi, ns);
        check($sformatf("vec%0d_line%0d_duty", v, j + 1), 32'(hi),
              32'(cnt_tab[int'(vecs[v].units[j]) + int'(vecs[v].trig[1] & ns)]));
      end
      check($sformatf("vec%0d_still_active", v), 32'(voice_active), 32'(vecs[v].trig));
    end

    // Latency and full decay length on voice 0.
    pulse_reset();
    tone_period = 32'h0000_0002;
    wait_frame();
    sync_tick();
    repeat (5) @(negedge clk);
    trigger = 4'b0001;
    @(negedge clk);
    check("decay_active_t1", 32'(voice_active), 32'd1);
    check("decay_sound_t1", 32'(sound), 32'd0);
    trigger = '0;
    @(negedge clk);
    check("decay_sound_t2", 32'(sound), 32'd1);
    sync_tick();
    wait_ticks(31 * ESL - 1);
    check("decay_last_tick_active", 32'(voice_active), 32'd1);
    @(negedge clk);
    check("decay_end_inactive", 32'(voice_active), 32'd0);

    // Retrigger mid-decay restarts the full envelope.
    pulse_reset();
    wait_frame();
    sync_tick();
    repeat (5) @(negedge clk);
    trigger = 4'b0001;
    @(negedge clk);
    trigger = '0;
    sync_tick();
    wait_ticks(74);
    repeat (5) @(negedge clk);
    trigger = 4'b0001;
    @(negedge clk);
    check("retrig_active", 32'(voice_active), 32'd1);
    trigger = '0;
    sync_tick();
    measure_line(hi, ns);
    check("retrig_env_full", 32'(hi), 32'd7);
    wait_ticks(31 * ESL - 2);
    check("retrig_last_tick_active", 32'(voice_active), 32'd1);
    @(negedge clk);
    check("retrig_end_inactive", 32'(voice_active), 32'd0);

    // Held trigger gives exactly one decay.
    pulse_reset();
    wait_frame();
    sync_tick();
    repeat (5) @(negedge clk);
    trigger = 4'b0001;
    @(negedge clk);
    check("held_start", 32'(voice_active), 32'd1);
    sync_tick();
    wait_ticks(31 * ESL - 1);
    check("held_last_tick_active", 32'(voice_active), 32'd1);
    @(negedge clk);
    check("held_end_inactive", 32'(voice_active), 32'd0);
    act = 0;
    repeat (40 * 64) begin
      @(negedge clk);
      act += int'(voice_active[0]);
    end
    check("held_stays_low", 32'(act), 32'd0);
    trigger = '0;

    // Reset mid-decay clears everything in the next cycle.
    pulse_reset();
    tone_period = 32'h0101_0101;
    wait_frame();
    sync_tick();
    repeat (5) @(negedge clk);
    trigger = 4'hF;
    @(negedge clk);
    check("rst_all_start", 32'(voice_active), 32'hF);
    wait_ticks(10);
    repeat (3) @(negedge clk);
    check("rst_pre_sound", 32'(sound), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_active", 32'(voice_active), 32'd0);
    check("rst_sound", 32'(sound), 32'd0);
    trigger = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_after_release", 32'(voice_active), 32'd0);

    // Mid-frame period change: latched build keeps the old period until frame_end.
    pulse_reset();
    tone_period = 32'h0000_0001;
    wait_frame();
    sync_tick();
    repeat (5) @(negedge clk);
    trigger = 4'b0001;
    @(negedge clk);
    trigger = '0;
    tone_period = 32'h0000_0000;
    sync_tick();
    for (int j = 0; j < 4; j++) begin
      measure_line(hi, ns);
`ifdef APU_FRAME_LATCH_EN
      check($sformatf("latch_line%0d", j + 1), 32'(hi), 32'((j % 2 == 1) ? 7 : 0));
`else
      check($sformatf("latch_line%0d", j + 1), 32'(hi), 32'd0);
`endif
    end
    check("latch_active", 32'(voice_active), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
